// File: rtl/slave_link_rx.sv
// Slave-side serial receiver for the inter-board link (start, data, ST, CLR, parity, stop).
// Optional watchdog output link_lost is built only when SLAVE_LINK_WDOG_EN is defined.
module slave_link_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_W       = 10
`ifdef SLAVE_LINK_WDOG_EN
  ,parameter int WDOG_CYCLES = 100_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] attack,
  output logic              st,
  output logic              clr_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy
`ifdef SLAVE_LINK_WDOG_EN
  ,output logic             link_lost
`endif
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int SW = DATA_W + 2;
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_ST_B,
    S_CLR_B, S_PAR, S_STOP, S_WAIT_HI
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_sync;
  logic [BW-1:0]   r_baud;
  logic [CW-1:0]   r_bcnt;
  logic [SW-1:0]   r_shift;
  logic            r_pbit;
  logic            r_valid;
  logic            r_err;
  logic [DATA_W-1:0] r_attack;
  logic            r_st;
  logic            r_clr;
  logic            w_rx;
  logic            w_tick;
  logic            w_par_bad;
  logic            w_valid;
  logic            w_err;

  assign w_rx      = r_sync[1];
  assign w_tick    = (r_baud == '0);
  assign w_par_bad = ^{r_pbit, r_shift};

  // two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state and status pulse decode
  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_rx) w_next = S_START;
      S_START: if (w_tick) begin
        w_next = w_rx ? S_IDLE : S_DATA;
        w_err  = w_rx;
      end
      S_DATA:  if (w_tick && r_bcnt == LAST) w_next = S_ST_B;
      S_ST_B:  if (w_tick) w_next = S_CLR_B;
      S_CLR_B: if (w_tick) w_next = S_PAR;
      S_PAR:   if (w_tick) w_next = S_STOP;
      S_STOP:  if (w_tick) begin
        if (!w_rx) begin
          w_err  = 1'b1;
          w_next = S_WAIT_HI;
        end else if (w_par_bad) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_valid = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_WAIT_HI: if (w_rx) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // baud/bit counters and shadow shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_pbit  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (!w_rx) begin
        r_baud <= HALF;
        r_bcnt <= '0;
      end
    end else if (r_state != S_WAIT_HI) begin
      if (w_tick) begin
        r_baud <= FULL;
        if (r_state == S_DATA)
          r_bcnt <= r_bcnt + CW'(1);
        if (r_state == S_DATA || r_state == S_ST_B ||
            r_state == S_CLR_B)
          r_shift <= {w_rx, r_shift[SW-1:1]};
        if (r_state == S_PAR)
          r_pbit <= w_rx;
      end else begin
        r_baud <= r_baud - BW'(1);
      end
    end
  end

  // registered outputs, updated only on a clean frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_attack <= '0;
      r_st     <= 1'b0;
      r_clr    <= 1'b0;
    end else begin
      r_valid <= w_valid;
      r_err   <= w_err;
      if (w_valid) begin
        r_attack <= r_shift[DATA_W-1:0];
        r_st     <= r_shift[DATA_W];
        r_clr    <= r_shift[DATA_W+1];
      end
    end
  end

  assign attack      = r_attack;
  assign st          = r_st;
  assign clr_out     = r_clr;
  assign frame_valid = r_valid;
  assign frame_err   = r_err;
  assign busy        = (r_state != S_IDLE);

`ifdef SLAVE_LINK_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_lost;

  // idle watchdog, saturating; cleared by each good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd   <= '0;
      r_lost <= 1'b1;
    end else if (r_valid) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else if (r_wd == WW'(WDOG_CYCLES)) begin
      r_lost <= 1'b1;
    end else begin
      r_wd <= r_wd + WW'(1);
    end
  end

  assign link_lost = r_lost;
`endif

endmodule

// File: tb/tb_slave_link_rx.sv
// Randomized bench for slave_link_rx with a frame-level reference model.
// Watchdog checks build only when SLAVE_LINK_WDOG_EN is defined.
module tb_slave_link_rx;
  localparam int CPB = 4;
  localparam int DW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] attack;
  logic          st, clr_out, frame_valid, frame_err, busy;
`ifdef SLAVE_LINK_WDOG_EN
  logic          link_lost;
`endif

  slave_link_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(DW)
`ifdef SLAVE_LINK_WDOG_EN
    ,.WDOG_CYCLES(200)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .attack(attack),
    .st(st),
    .clr_out(clr_out),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .busy(busy)
`ifdef SLAVE_LINK_WDOG_EN
    ,.link_lost(link_lost)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int            exp_fv = 0;
  int            exp_fe = 0;
  logic [DW-1:0] ea = '0;
  logic          es = 1'b0;
  logic          ec = 1'b0;

  // pulse monitor
  int cyc = 0;
  int n_fv = 0, n_fe = 0, n_both = 0, n_glitch = 0;
  int t_fv_prev = 0, t_fv_last = 0;
  logic [DW+1:0] prev_out = '0;

  always @(negedge clk) begin
    cyc++;
    if (frame_valid) begin
      n_fv++;
      t_fv_prev = t_fv_last;
      t_fv_last = cyc;
    end
    if (frame_err) n_fe++;
    if (frame_valid && frame_err) n_both++;
    if (rst_n && !frame_valid && {clr_out, st, attack} != prev_out)
      n_glitch++;
    prev_out = {clr_out, st, attack};
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic s,
                            input logic c, input logic pflip,
                            input logic stopb);
    logic p;
    p = (^{c, s, d}) ^ pflip;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(s);
    send_bit(c);
    send_bit(p);
    send_bit(stopb);
    if (!stopb || pflip) exp_fe++;
    else begin
      exp_fv++;
      ea = d;
      es = s;
      ec = c;
    end
  endtask

  task automatic glitch();
    rx = 1'b0;
    @(negedge clk);
    idle(8);
    exp_fe++;
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ea = '0;
    es = 1'b0;
    ec = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_nvalid"}, n_fv, exp_fv);
    chk({tag, "_nerr"}, n_fe, exp_fe);
    chk({tag, "_attack"}, attack, ea);
    chk({tag, "_st"}, st, es);
    chk({tag, "_clr"}, clr_out, ec);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int kind, g;
    logic [DW-1:0] d;
    logic s, c;

    @(negedge clk);
    chk("rst_attack", attack, 0);
    chk("rst_st", st, 0);
    chk("rst_clr", clr_out, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
`ifdef SLAVE_LINK_WDOG_EN
    chk("rst_lost", link_lost, 1);
`endif
    do_reset();

    send_frame(10'h2A5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkpoint("good");

    do_reset();
    send_frame(10'h2A5, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    checkpoint("parity");

    glitch();
    checkpoint("glitch");

    send_frame(10'h155, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_busy", busy, 1);
    chk("hold_nerr", n_fe, exp_fe);
    idle(5);
    chk("hold_release_busy", busy, 0);
    send_frame(10'h001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkpoint("after_hold");

    d = 10'h3F1;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_attack", attack, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ea = '0;
    es = 1'b0;
    ec = 1'b0;
    for (int i = 5; i < DW; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(^{2'b11, d});
    send_bit(1'b1);
    idle(10);
    checkpoint("abort");
    send_frame(10'h0C3, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(4);
    checkpoint("post_abort");

    send_frame(10'h3FF, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkpoint("b2b");
    chk("b2b_spacing", t_fv_last - t_fv_prev, 60);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      d = DW'($urandom_range(0, 1023));
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      case (kind)
        0: send_frame(d, s, c, 1'b1, 1'b1);
        1: send_frame(d, s, c, 1'b0, 1'b0);
        2: glitch();
        default: send_frame(d, s, c, 1'b0, 1'b1);
      endcase
      g = (kind == 1) ? 3 + $urandom_range(0, 3)
                      : $urandom_range(0, 5);
      idle(g);
      if (g >= 3) checkpoint("rnd");
    end
    idle(6);
    checkpoint("rnd_end");

`ifdef SLAVE_LINK_WDOG_EN
    send_frame(10'h1A2, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("wd_cleared", link_lost, 0);
    for (int k = 0; k < 400 && (cyc - t_fv_last) < 190; k++)
      @(negedge clk);
    chk("wd_before", link_lost, 0);
    for (int k = 0; k < 400 && (cyc - t_fv_last) < 215; k++)
      @(negedge clk);
    chk("wd_after", link_lost, 1);
`endif

    chk("valid_err_overlap", n_both, 0);
    chk("output_change_no_valid", n_glitch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_link_rx.md
Name: slave_link_rx

Overview:
- Slave-board (player B) serial receiver for the inter-board link.
- The master board's link transmitter sends its attack vector plus ST and clr status over one wire. This block deserializes those frames and presents registered fields to the slave top level.
- A single wire replaces the parallel 12-wire cable between the boards.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); minimum 4, must be even.
- DATA_W, 10, attack vector width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line from master; idles high.
- attack  output  DATA_W  last valid attack vector received.
- st  output  1  last valid master ST bit.
- clr_out  output  1  last valid master clr bit.
- frame_valid  output  1  one-cycle pulse; outputs were updated this cycle.
- frame_err  output  1  one-cycle pulse; frame discarded (parity, stop or false start).
- busy  output  1  high while a frame is being received.

Behaviour:
- Frame format, in line order:
  - start bit (0)
  - DATA_W data bits, LSB first
  - ST bit
  - CLR bit
  - even parity bit over data+ST+CLR
  - stop bit (1)
  - Total frame length is DATA_W+5 bits.
- rx passes through a 2-flop synchronizer (reset value 1) before any use. Synchronizer latency is 2 cycles.
- Reset values: attack=0, st=0, clr_out=0, frame_valid=0, frame_err=0, busy=0, FSM in IDLE, counters 0.
- FSM states: IDLE, START, DATA, ST_B, CLR_B, PAR, STOP, WAIT_HI.
  - IDLE: on a synchronized falling level (rx_s=0), go to START, clear the bit counter, load the baud counter.
  - START: sample at CLKS_PER_BIT/2 cycles. If rx_s=1, this is a false start: pulse frame_err and return to IDLE. Otherwise go to DATA.
  - DATA, ST_B, CLR_B, PAR: each samples rx_s once, CLKS_PER_BIT cycles after the previous sample (mid-bit). Bits shift into a shadow register. DATA exits after exactly DATA_W samples.
  - STOP: sample at mid-bit.
    - If stop=1 and parity is good: copy the shadow into attack/st/clr_out, pulse frame_valid, go to IDLE.
    - If stop=0: pulse frame_err, discard the shadow, go to WAIT_HI.
    - If parity is bad: pulse frame_err, discard the shadow, go to IDLE.
  - WAIT_HI: stay until rx_s=1, then go to IDLE. A held-low line (break or unplugged cable) never produces repeated errors.
- Output latency: frame_valid asserts on the cycle after the stop-bit mid-sample. attack/st/clr_out change only in that same cycle.
- busy=1 in every state except IDLE.
- frame_valid and frame_err are never asserted in the same cycle.
- Outputs hold across errored frames; there is no partial update.
- Baud counter width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_W+1).
- Reset asserted mid-frame: all state returns to reset values immediately. After release, the FSM waits in IDLE for a fresh start edge.
- Back-to-back frames (stop bit followed immediately by the next start bit) must be received without loss. The IDLE→START transition takes ≤1 cycle after STOP.

Optional Feature:
- SLAVE_LINK_WDOG_EN: adds output link_lost (1 bit, reset value 1) and parameter WDOG_CYCLES (default 100_000_000).
  - A counter resets on every frame_valid and clears link_lost.
  - When the count reaches WDOG_CYCLES, link_lost is set and the counter saturates.
- Without the macro: no port, no parameter, no counter.

Test Plan (CLKS_PER_BIT=4, DATA_W=10):
- Reset, then send frame attack=10'h2A5, ST=1, CLR=0, parity correct → one frame_valid pulse; attack=10'h2A5, st=1, clr_out=0; frame_err never high.
- Same frame with parity bit flipped → one frame_err pulse; attack/st/clr_out still hold reset values; no frame_valid.
- 1-cycle low glitch on idle rx → frame_err pulse at the START mid-sample; FSM back in IDLE; outputs unchanged.
- Stop bit driven 0 and rx then held low 50 cycles → exactly one frame_err pulse; busy stays 1 until rx returns high; next good frame (10'h001) is received correctly.
- Two back-to-back good frames (10'h3FF CLR=1, then 10'h000 CLR=0) → two frame_valid pulses 60 cycles apart; final attack=0, clr_out=0.
- rst_n pulsed low mid-DATA of a frame → outputs return to 0 asynchronously; the remainder of the aborted frame produces no frame_valid; a subsequent full frame is received correctly. With SLAVE_LINK_WDOG_EN and WDOG_CYCLES=200: link_lost clears on frame_valid and sets 200 idle cycles later.
